// File: rtl/register_bank_if.sv
// Bundles the write, issue and dual-read signals of the register bank.
// The master side drives requests; the slave side returns registered read results.
interface register_bank_if #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5
);
   logic                 RegWrite;
   logic [ADDR_BITS-1:0] Write_Register;
   logic [WIDTH-1:0]     Write_Data;
   logic                 Read_Enable;
   logic [ADDR_BITS-1:0] Read_Register1;
   logic [ADDR_BITS-1:0] Read_Register2;
   logic [WIDTH-1:0]     Read_Data1;
   logic [WIDTH-1:0]     Read_Data2;
   logic                 Read_Pending1;
   logic                 Read_Pending2;
   logic                 Read_Valid;
   logic                 Issue_Valid;
   logic [ADDR_BITS-1:0] Issue_Register;
   logic                 Any_Pending;

   modport master (
      output RegWrite, Write_Register, Write_Data,
      output Read_Enable, Read_Register1, Read_Register2,
      output Issue_Valid, Issue_Register,
      input  Read_Data1, Read_Data2, Read_Pending1, Read_Pending2,
      input  Read_Valid, Any_Pending
   );

   modport slave (
      input  RegWrite, Write_Register, Write_Data,
      input  Read_Enable, Read_Register1, Read_Register2,
      input  Issue_Valid, Issue_Register,
      output Read_Data1, Read_Data2, Read_Pending1, Read_Pending2,
      output Read_Valid, Any_Pending
   );
endinterface

// File: rtl/register_bank.sv
// General-purpose register bank: two registered read ports with write bypass,
// one write port, and a per-register pending scoreboard set at issue, cleared at writeback.
module register_bank #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5,
   parameter bit ZERO_REG  = 1'b1
) (
   input  logic Clock,
   input  logic Reset,
   register_bank_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] IDX_ZERO = {ADDR_BITS{1'b0}};
   localparam logic [DEPTH-1:0]     ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0] pending_r;
   logic [DEPTH-1:0] pending_next_s;
   logic [DEPTH-1:0] clr_mask_s;
   logic [DEPTH-1:0] set_mask_s;
   logic             write_en_s;
   logic             issue_en_s;
   logic [WIDTH:0]   port1_s;
   logic [WIDTH:0]   port2_s;
   logic [WIDTH-1:0] rd1_data_r;
   logic [WIDTH-1:0] rd2_data_r;
   logic             rd1_pend_r;
   logic             rd2_pend_r;
   logic             read_valid_r;
   logic             any_pending_r;

   function automatic logic is_hardzero(input logic [ADDR_BITS-1:0] idx);
      return ZERO_REG && (idx == IDX_ZERO);
   endfunction

   // Result is {pending, data}; an issue only shows same-cycle when it coincides with a bypassed write.
   function automatic logic [WIDTH:0] resolve_port(
      input logic [ADDR_BITS-1:0] idx,
      input logic [WIDTH-1:0]     stored_data,
      input logic                 stored_pend,
      input logic                 we,
      input logic [ADDR_BITS-1:0] wa,
      input logic [WIDTH-1:0]     wd,
      input logic                 iv,
      input logic [ADDR_BITS-1:0] ia
   );
      logic [WIDTH:0] res;
      if (is_hardzero(idx)) begin
         res = {1'b0, {WIDTH{1'b0}}};
      end else if (we && (wa == idx)) begin
         res = {(iv && (ia == idx)), wd};
      end else begin
         res = {stored_pend, stored_data};
      end
      return res;
   endfunction

   // Scoreboard next state: clear on writeback, then set on issue so the new producer wins.
   always_comb begin
      write_en_s     = bus.RegWrite && !is_hardzero(bus.Write_Register);
      issue_en_s     = bus.Issue_Valid && !is_hardzero(bus.Issue_Register);
      clr_mask_s     = write_en_s ? (ONE_HOT0 << bus.Write_Register) : {DEPTH{1'b0}};
      set_mask_s     = issue_en_s ? (ONE_HOT0 << bus.Issue_Register) : {DEPTH{1'b0}};
      pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
   end

   // Per-port operand resolution for this cycle's read.
   always_comb begin
      port1_s = {(WIDTH+1){1'b0}};
      port2_s = {(WIDTH+1){1'b0}};
      port1_s = resolve_port(bus.Read_Register1, regs_r[bus.Read_Register1],
                             pending_r[bus.Read_Register1], bus.RegWrite,
                             bus.Write_Register, bus.Write_Data,
                             bus.Issue_Valid, bus.Issue_Register);
      port2_s = resolve_port(bus.Read_Register2, regs_r[bus.Read_Register2],
                             pending_r[bus.Read_Register2], bus.RegWrite,
                             bus.Write_Register, bus.Write_Data,
                             bus.Issue_Valid, bus.Issue_Register);
   end

   // Register file storage.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
      end else if (write_en_s) begin
         regs_r[bus.Write_Register] <= bus.Write_Data;
      end
   end

   // Scoreboard and registered read outputs; read outputs hold when no read is accepted.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pending_r     <= {DEPTH{1'b0}};
         any_pending_r <= 1'b0;
         read_valid_r  <= 1'b0;
         rd1_data_r    <= {WIDTH{1'b0}};
         rd2_data_r    <= {WIDTH{1'b0}};
         rd1_pend_r    <= 1'b0;
         rd2_pend_r    <= 1'b0;
      end else begin
         pending_r     <= pending_next_s;
         any_pending_r <= |pending_next_s;
         read_valid_r  <= bus.Read_Enable;
         if (bus.Read_Enable) begin
            rd1_data_r <= port1_s[WIDTH-1:0];
            rd2_data_r <= port2_s[WIDTH-1:0];
            rd1_pend_r <= port1_s[WIDTH];
            rd2_pend_r <= port2_s[WIDTH];
         end
      end
   end

   assign bus.Read_Data1    = rd1_data_r;
   assign bus.Read_Data2    = rd2_data_r;
   assign bus.Read_Pending1 = rd1_pend_r;
   assign bus.Read_Pending2 = rd2_pend_r;
   assign bus.Read_Valid    = read_valid_r;
   assign bus.Any_Pending   = any_pending_r;
endmodule

// File: tb/tb_register_bank.sv
// Drives a ZERO_REG=1 and a ZERO_REG=0 register bank with identical stimulus and
// compares both against an array-based reference model of the register/scoreboard rules.
module tb_register_bank;
   logic Clock;
   logic Reset;
   int   n_checks;
   int   n_fail;

   register_bank_if #(.WIDTH(32), .ADDR_BITS(5)) if_z ();
   register_bank_if #(.WIDTH(32), .ADDR_BITS(5)) if_o ();

   register_bank #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b1)) dut_z (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (if_z.slave)
   );

   register_bank #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b0)) dut_o (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (if_o.slave)
   );

   // Reference state, index 0 = ZERO_REG=1 build, index 1 = ZERO_REG=0 build.
   logic [31:0] mem   [2][32];
   logic        pend  [2][32];
   logic [31:0] exp_d1 [2];
   logic [31:0] exp_d2 [2];
   logic        exp_p1 [2];
   logic        exp_p2 [2];
   logic        exp_v  [2];
   logic        exp_any[2];

   // Free-running clock.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 32; i++) begin
            mem[b][i]  = 32'h0;
            pend[b][i] = 1'b0;
         end
         exp_d1[b] = 32'h0; exp_d2[b] = 32'h0;
         exp_p1[b] = 1'b0;  exp_p2[b] = 1'b0;
         exp_v[b]  = 1'b0;  exp_any[b] = 1'b0;
      end
   endtask

   // Value a read of idx observes this cycle: {pending, data}.
   function automatic logic [32:0] model_read(input int b, input logic [4:0] idx,
                                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                              input logic iv, input logic [4:0] ia);
      if (b == 0 && idx == 5'd0) return {1'b0, 32'h0};
      if (we && wa == idx) return {(iv && ia == idx), wd};
      return {pend[b][idx], mem[b][idx]};
   endfunction

   task automatic model_step(input int b, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                             input logic re, input logic [4:0] r1, input logic [4:0] r2,
                             input logic iv, input logic [4:0] ia);
      logic [32:0] v1;
      logic [32:0] v2;
      logic        any;
      v1 = model_read(b, r1, we, wa, wd, iv, ia);
      v2 = model_read(b, r2, we, wa, wd, iv, ia);
      exp_v[b] = re;
      if (re) begin
         exp_d1[b] = v1[31:0]; exp_p1[b] = v1[32];
         exp_d2[b] = v2[31:0]; exp_p2[b] = v2[32];
      end
      if (we && !(b == 0 && wa == 5'd0)) begin
         mem[b][wa]  = wd;
         pend[b][wa] = 1'b0;
      end
      if (iv && !(b == 0 && ia == 5'd0)) pend[b][ia] = 1'b1;
      any = 1'b0;
      for (int i = 0; i < 32; i++) any = any | pend[b][i];
      exp_any[b] = any;
   endtask

   task automatic compare_all();
      check_value("z.rd1",   if_z.Read_Data1,    exp_d1[0]);
      check_value("z.rd2",   if_z.Read_Data2,    exp_d2[0]);
      check_value("z.pend1", if_z.Read_Pending1, exp_p1[0]);
      check_value("z.pend2", if_z.Read_Pending2, exp_p2[0]);
      check_value("z.valid", if_z.Read_Valid,    exp_v[0]);
      check_value("z.any",   if_z.Any_Pending,   exp_any[0]);
      check_value("o.rd1",   if_o.Read_Data1,    exp_d1[1]);
      check_value("o.rd2",   if_o.Read_Data2,    exp_d2[1]);
      check_value("o.pend1", if_o.Read_Pending1, exp_p1[1]);
      check_value("o.pend2", if_o.Read_Pending2, exp_p2[1]);
      check_value("o.valid", if_o.Read_Valid,    exp_v[1]);
      check_value("o.any",   if_o.Any_Pending,   exp_any[1]);
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] r1, input logic [4:0] r2,
                        input logic iv, input logic [4:0] ia);
      if_z.RegWrite = we; if_z.Write_Register = wa; if_z.Write_Data = wd;
      if_z.Read_Enable = re; if_z.Read_Register1 = r1; if_z.Read_Register2 = r2;
      if_z.Issue_Valid = iv; if_z.Issue_Register = ia;
      if_o.RegWrite = we; if_o.Write_Register = wa; if_o.Write_Data = wd;
      if_o.Read_Enable = re; if_o.Read_Register1 = r1; if_o.Read_Register2 = r2;
      if_o.Issue_Valid = iv; if_o.Issue_Register = ia;
   endtask

   task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] r1, input logic [4:0] r2,
                       input logic iv, input logic [4:0] ia);
      @(negedge Clock);
      drive(we, wa, wd, re, r1, r2, iv, ia);
      @(posedge Clock);
      for (int b = 0; b < 2; b++) model_step(b, we, wa, wd, re, r1, r2, iv, ia);
      #1;
      compare_all();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
   task automatic mid_reset();
      @(negedge Clock);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      #2;
      Reset = 1'b1;
      #1;
      model_clear();
      compare_all();
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      model_clear();
      #3;
      compare_all();
      @(negedge Clock);
      Reset = 1'b0;

      // Basic write then read on both ports.
      step(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0);
      check_value("basic.d1", if_z.Read_Data1, 32'h12345678);
      check_value("basic.d2", if_z.Read_Data2, 32'h12345678);
      check_value("basic.valid", if_z.Read_Valid, 1'b1);

      // Same-cycle bypass; r0 stays zero on the hardwired build.
      step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0);
      check_value("bypass.d1", if_z.Read_Data1, 32'hA5A5A5A5);
      check_value("bypass.d2", if_z.Read_Data2, 32'h0);
      check_value("bypass.p1", if_z.Read_Pending1, 1'b0);

      // Scoreboard set by issue, cleared by writeback.
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0);
      check_value("sb.p1", if_z.Read_Pending1, 1'b1);
      check_value("sb.any", if_z.Any_Pending, 1'b1);
      step(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0);
      check_value("sb.clr.p1", if_z.Read_Pending1, 1'b0);
      check_value("sb.clr.d1", if_z.Read_Data1, 32'h55);
      check_value("sb.clr.any", if_z.Any_Pending, 1'b0);

      // Set wins over clear on the same index; data still lands.
      step(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0);
      check_value("svc.p1", if_z.Read_Pending1, 1'b1);
      check_value("svc.d1", if_z.Read_Data1, 32'h11);

      // r0 behaviour: ordinary on one build, hardwired on the other.
      step(1'b1, 5'd0, 32'hFFFF0000, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
      check_value("r0.o.d1", if_o.Read_Data1, 32'hFFFF0000);
      check_value("r0.z.d1", if_z.Read_Data1, 32'h0);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
      check_value("r0.o.p1", if_o.Read_Pending1, 1'b1);
      check_value("r0.z.p1", if_z.Read_Pending1, 1'b0);

      // Mid-run reset wipes stored data.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
      mid_reset();
      check_value("rst.z.any", if_z.Any_Pending, 1'b0);
      check_value("rst.o.d1", if_o.Read_Data1, 32'h0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0);
      check_value("rst.r5.d1", if_z.Read_Data1, 32'h0);
      check_value("rst.r5.p1", if_z.Read_Pending1, 1'b0);

      // Randomized traffic, biased to a few registers so collisions are frequent.
      for (int n = 0; n < 600; n++) begin
         logic [4:0] wa, r1, r2, ia;
         bit narrow;
         narrow = ($urandom_range(0, 3) != 0);
         wa = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         r1 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         r2 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         ia = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 149) == 0) begin
            mid_reset();
         end else begin
            step(1'($urandom_range(0, 1)), wa, 32'($urandom),
                 1'($urandom_range(0, 3) != 0), r1, r2,
                 1'($urandom_range(0, 2) == 0), ia);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
